// File: rtl/led_rx_pkg.sv
// Shared types and constants for the LED frame receiver: FSM state codes,
// payload geometry and the default frame start marker.
package led_rx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_HDR    = 3'd1;
  localparam state_t ST_PAY    = 3'd2;
  localparam state_t ST_CHK    = 3'd3;
  localparam state_t ST_COMMIT = 3'd4;

  localparam int PAYLOAD_BYTES = 24;
  localparam int BYTES_PER_CH  = 6;
  localparam int CH_W          = 48;
  localparam int NUM_CH        = 4;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/led_frame_rx_if.sv
// Byte-stream valid/ready link feeding the frame receiver.
// The master drives data and valid; the slave drives ready.
interface led_frame_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/led_rx_chk.sv
// Running 8-bit XOR over accepted frame bytes; the result is a registered value
// updated one cycle after en_i, and clr_i takes priority over en_i.
module led_rx_chk (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] dat_i,
  output logic [7:0] val_o
);

  logic [7:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = 8'h00;
    end else if (en_i) begin
      val_d = val_q ^ dat_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= 8'h00;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/led_frame_rx.sv
// Frame receiver: parses SYNC/header/24 payload bytes into shadow registers and commits them atomically
// one cycle after the last byte; stalls input only during COMMIT. Optional trailing checksum under RX_CHECKSUM_EN.
module led_frame_rx
  import led_rx_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 1000,
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE
) (
  input  logic            sys_clk,
  input  logic            sys_reset,
  led_frame_rx_if.slave   rx,
  output logic [3:0]      CMD,
  output logic [CH_W-1:0] DATA_o0,
  output logic [CH_W-1:0] DATA_o1,
  output logic [CH_W-1:0] DATA_o2,
  output logic [CH_W-1:0] DATA_o3,
  output logic            CTS,
  output logic            error_flag
);

  localparam int IW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t                      state_q, state_d;
  logic [4:0]                  byte_cnt_q, byte_cnt_d;
  logic [IW-1:0]               idle_q, idle_d;
  logic [3:0]                  sh_cmd_q, sh_cmd_d;
  logic [NUM_CH-1:0][CH_W-1:0] sh_dat_q, sh_dat_d;
  logic [3:0]                  cmd_q;
  logic [NUM_CH-1:0][CH_W-1:0] dat_q;
  logic                        err_q, err_d;
  logic                        commit;
  logic                        acc;
  logic                        in_frame;
  logic                        tmo;
  logic [1:0]                  ch_idx;

  assign acc         = rx.rx_valid && rx.rx_ready;
  assign rx.rx_ready = (state_q != ST_COMMIT);
  assign in_frame    = (state_q == ST_HDR) || (state_q == ST_PAY) || (state_q == ST_CHK);
  assign ch_idx      = 2'(byte_cnt_q / 5'(BYTES_PER_CH));
  // A byte accepted on the same edge the idle count would expire takes precedence.
  assign tmo         = (TIMEOUT_CYC != 0) && in_frame && !acc &&
                       (idle_q == IW'(TIMEOUT_CYC - 1));

`ifdef RX_CHECKSUM_EN
  logic       chk_clr;
  logic       chk_en;
  logic [7:0] chk_val;

  assign chk_clr = (state_q == ST_IDLE);
  assign chk_en  = acc && ((state_q == ST_HDR) || (state_q == ST_PAY));

  led_rx_chk u_chk (
    .clk   (sys_clk),
    .rst   (sys_reset),
    .clr_i (chk_clr),
    .en_i  (chk_en),
    .dat_i (rx.rx_data),
    .val_o (chk_val)
  );
`endif

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    idle_d     = idle_q;
    sh_cmd_d   = sh_cmd_q;
    sh_dat_d   = sh_dat_q;
    err_d      = err_q;
    commit     = 1'b0;

    if (in_frame) begin
      idle_d = acc ? '0 : idle_q + IW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        idle_d     = '0;
        byte_cnt_d = '0;
        if (acc && (rx.rx_data == SYNC_BYTE)) begin
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (acc) begin
          sh_cmd_d = rx.rx_data[7:4];
          state_d  = ST_PAY;
        end
      end
      ST_PAY: begin
        if (acc) begin
          sh_dat_d[ch_idx] = {sh_dat_q[ch_idx][CH_W-9:0], rx.rx_data};
          byte_cnt_d       = byte_cnt_q + 5'd1;
          if (byte_cnt_q == 5'(PAYLOAD_BYTES - 1)) begin
`ifdef RX_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_COMMIT;
`endif
          end
        end
      end
`ifdef RX_CHECKSUM_EN
      ST_CHK: begin
        if (acc) begin
          if (rx.rx_data == chk_val) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      ST_COMMIT: begin
        commit  = 1'b1;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (tmo) begin
      state_d  = ST_IDLE;
      err_d    = 1'b1;
      sh_cmd_d = '0;
      sh_dat_d = '0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      idle_q     <= '0;
      sh_cmd_q   <= '0;
      sh_dat_q   <= '0;
      cmd_q      <= '0;
      dat_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      idle_q     <= idle_d;
      sh_cmd_q   <= sh_cmd_d;
      sh_dat_q   <= sh_dat_d;
      err_q      <= err_d;
      if (commit) begin
        cmd_q <= sh_cmd_q;
        dat_q <= sh_dat_q;
      end
    end
  end

  assign CMD        = cmd_q;
  assign DATA_o0    = dat_q[0];
  assign DATA_o1    = dat_q[1];
  assign DATA_o2    = dat_q[2];
  assign DATA_o3    = dat_q[3];
  assign CTS        = (state_q != ST_IDLE);
  assign error_flag = err_q;

endmodule

// File: tb/tb_led_frame_rx.sv
// Directed bench for led_frame_rx: a table of good frames plus hand sequences for
// checksum error, timeout and its boundary, leading garbage, reset mid-frame and back-to-back frames.
module tb_led_frame_rx;
  import led_rx_pkg::*;

  localparam int TO = 16;
`ifdef RX_CHECKSUM_EN
  localparam int FLEN = 27;
`else
  localparam int FLEN = 26;
`endif

  logic        sys_clk;
  logic        sys_reset;
  logic [3:0]  CMD;
  logic [47:0] DATA_o0, DATA_o1, DATA_o2, DATA_o3;
  logic        CTS, error_flag;

  led_frame_rx_if rx_if ();

  led_frame_rx #(.TIMEOUT_CYC(TO), .SYNC_BYTE(8'hA5)) dut (
    .sys_clk    (sys_clk),
    .sys_reset  (sys_reset),
    .rx         (rx_if),
    .CMD        (CMD),
    .DATA_o0    (DATA_o0),
    .DATA_o1    (DATA_o1),
    .DATA_o2    (DATA_o2),
    .DATA_o3    (DATA_o3),
    .CTS        (CTS),
    .error_flag (error_flag)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int cts_cnt = 0;
  int rdy_lo  = 0;
  int chg_cyc[$];
  logic [47:0] prev_d0 = '0;
  logic [7:0]  fr [0:26];

  always @(posedge sys_clk) cyc++;
  always @(negedge sys_clk) begin
    if (CTS) cts_cnt++;
    if (!rx_if.rx_ready) rdy_lo++;
    if (DATA_o0 !== prev_d0) begin
      chg_cyc.push_back(cyc);
      prev_d0 = DATA_o0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r;
    int   tries;
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = b;
    tries = 0;
    do begin
      @(negedge sys_clk);
      r = rx_if.rx_ready;
      @(posedge sys_clk);
      #1;
      tries++;
    end while (!r && tries < 8);
    if (!r) begin
      total++;
      $display("FAIL byte_accept: ready stayed 0 for byte %h", b);
    end
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(fr[i]);
    rx_if.rx_valid = 1'b0;
  endtask

  task automatic build_frame(input logic [7:0] hdr, input logic [7:0] base, input logic [7:0] chx);
    logic [7:0] cs;
    cs    = hdr;
    fr[0] = 8'hA5;
    fr[1] = hdr;
    for (int i = 0; i < 24; i++) begin
      fr[2+i] = base + 8'(i);
      cs      = cs ^ fr[2+i];
    end
    fr[26] = cs ^ chx;
  endtask

  typedef struct {
    logic [7:0]  hdr;
    logic [7:0]  base;
    logic [3:0]  cmd;
    logic [47:0] d0;
    logic [47:0] d3;
  } vec_t;

  vec_t tbl [4];
  int   diff;

  initial begin
    tbl[0] = '{8'hE0, 8'h01, 4'hE, 48'h010203040506, 48'h131415161718};
    tbl[1] = '{8'h3C, 8'h20, 4'h3, 48'h202122232425, 48'h323334353637};
    tbl[2] = '{8'hA5, 8'hF0, 4'hA, 48'hF0F1F2F3F4F5, 48'h020304050607};
    tbl[3] = '{8'h0F, 8'hA5, 4'h0, 48'hA5A6A7A8A9AA, 48'hB7B8B9BABBBC};

    sys_reset = 1'b1;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    #2;
    chk("rst_ready", rx_if.rx_ready, 1);
    chk("rst_cmd", CMD, 0);
    chk("rst_d0", DATA_o0, 0);
    chk("rst_d3", DATA_o3, 0);
    chk("rst_cts", CTS, 0);
    chk("rst_err", error_flag, 0);
    @(posedge sys_clk); #1;
    sys_reset = 1'b0;
    @(posedge sys_clk); #1;

    for (int i = 0; i < 4; i++) begin
      build_frame(tbl[i].hdr, tbl[i].base, 8'h00);
      cts_cnt = 0;
      send_range(0, FLEN - 1);
      chk("cts_in_commit", CTS, 1);
      chk("ready_in_commit", rx_if.rx_ready, 0);
      @(posedge sys_clk); #1;
      chk("tbl_cmd", CMD, tbl[i].cmd);
      chk("tbl_d0", DATA_o0, tbl[i].d0);
      chk("tbl_d3", DATA_o3, tbl[i].d3);
      chk("tbl_err", error_flag, 0);
      chk("tbl_cts_low", CTS, 0);
      chk("tbl_cts_cycles", cts_cnt, FLEN);
    end

`ifdef RX_CHECKSUM_EN
    build_frame(8'hE0, 8'h01, 8'h01);
    send_range(0, FLEN - 1);
    chk("badchk_err", error_flag, 1);
    chk("badchk_cts", CTS, 0);
    @(posedge sys_clk); #1;
    chk("badchk_cmd_held", CMD, tbl[3].cmd);
    chk("badchk_d0_held", DATA_o0, tbl[3].d0);
`endif

    build_frame(8'hE0, 8'h01, 8'h00);
    send_range(0, 7);
    repeat (TO - 1) @(posedge sys_clk);
    #1;
    chk("tmo_before_err", error_flag, 0);
    chk("tmo_before_cts", CTS, 1);
    @(posedge sys_clk); #1;
    chk("tmo_err", error_flag, 1);
    chk("tmo_cts", CTS, 0);
    chk("tmo_cmd_held", CMD, tbl[3].cmd);
    chk("tmo_d0_held", DATA_o0, tbl[3].d0);
    send_range(0, FLEN - 1);
    @(posedge sys_clk); #1;
    chk("after_tmo_cmd", CMD, 4'hE);
    chk("after_tmo_d0", DATA_o0, 48'h010203040506);
    chk("after_tmo_err", error_flag, 0);

    build_frame(8'h70, 8'h50, 8'h00);
    send_range(0, 7);
    repeat (TO - 1) @(posedge sys_clk);
    #1;
    send_range(8, 8);
    chk("tmo_edge_err", error_flag, 0);
    chk("tmo_edge_cts", CTS, 1);
    send_range(9, FLEN - 1);
    @(posedge sys_clk); #1;
    chk("tmo_edge_cmd", CMD, 4'h7);
    chk("tmo_edge_d0", DATA_o0, 48'h505152535455);

    fr[0] = 8'h00; fr[1] = 8'hFF; fr[2] = 8'h5A;
    send_range(0, 2);
    chk("garbage_cts", CTS, 0);
    chk("garbage_err", error_flag, 0);
    build_frame(8'hC0, 8'h30, 8'h00);
    send_range(0, FLEN - 1);
    @(posedge sys_clk); #1;
    chk("garbage_cmd", CMD, 4'hC);
    chk("garbage_d0", DATA_o0, 48'h303132333435);

    build_frame(8'h90, 8'h60, 8'h00);
    send_range(0, 11);
    sys_reset = 1'b1;
    #1;
    chk("midrst_cmd", CMD, 0);
    chk("midrst_d0", DATA_o0, 0);
    chk("midrst_d3", DATA_o3, 0);
    chk("midrst_cts", CTS, 0);
    chk("midrst_err", error_flag, 0);
    chk("midrst_ready", rx_if.rx_ready, 1);
    @(posedge sys_clk); #1;
    sys_reset = 1'b0;
    @(posedge sys_clk); #1;
    build_frame(8'hB0, 8'h70, 8'h00);
    send_range(0, FLEN - 1);
    @(posedge sys_clk); #1;
    chk("postrst_cmd", CMD, 4'hB);
    chk("postrst_d0", DATA_o0, 48'h707172737475);
    chk("postrst_d3", DATA_o3, 48'h828384858687);

    chg_cyc.delete();
    build_frame(8'hD0, 8'h10, 8'h00);
    send_range(0, FLEN - 1);
    rdy_lo = 0;
    build_frame(8'h20, 8'h80, 8'h00);
    send_range(0, FLEN - 1);
    chk("b2b_ready_low", rdy_lo, 1);
    @(posedge sys_clk); #1;
    chk("b2b_cmd", CMD, 4'h2);
    chk("b2b_d0", DATA_o0, 48'h808182838485);
    chk("b2b_d3", DATA_o3, 48'h929394959697);
    chk("b2b_commits", chg_cyc.size(), 2);
    diff = (chg_cyc.size() >= 2) ? chg_cyc[1] - chg_cyc[0] : -1;
    chk("b2b_spacing", 64'(diff), 64'(FLEN + 1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
